// File: rtl/sw_pkg.sv
// Shared constants and helpers for the stopwatch time register: field limits,
// BCD word layout and a two-digit binary-to-BCD converter.
package sw_pkg;
  localparam int NUM_FIELDS  = 4;
  localparam int FW          = 7;   // wide enough for any field value 0..99
  localparam int MS_MAX_DEF  = 99;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 59;
  localparam int HR_MAX_DEF  = 23;

  localparam int BCD_MS_LSB  = 0;
  localparam int BCD_SEC_LSB = 8;
  localparam int BCD_MIN_LSB = 16;
  localparam int BCD_HR_LSB  = 24;

  function automatic logic [7:0] bin2bcd2(input logic [FW-1:0] v);
    logic [3:0] tens, units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {tens, units};
  endfunction
endpackage

// File: rtl/stopwatch_time_counter_if.sv
// Strobe/status bundle between the stopwatch control (master) and the time
// register (slave).
interface stopwatch_time_counter_if #(
  parameter int MS_MAX  = 99,
  parameter int SEC_MAX = 59,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23
);
  localparam int MS_W  = $clog2(MS_MAX + 1);
  localparam int SEC_W = $clog2(SEC_MAX + 1);
  localparam int MIN_W = $clog2(MIN_MAX + 1);
  localparam int HR_W  = $clog2(HR_MAX + 1);

  logic             i_en;
  logic             i_ms_up, i_ms_down;
  logic             i_sec_up, i_sec_down;
  logic             i_min_up, i_min_down;
  logic             i_hr_up, i_hr_down;
  logic             o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup;
  logic [MS_W-1:0]  o_ms;
  logic [SEC_W-1:0] o_sec;
  logic [MIN_W-1:0] o_min;
  logic [HR_W-1:0]  o_hr;
  logic [31:0]      o_bcd;
  logic             o_ovf;

  modport master (
    output i_en, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    input  o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup,
           o_ms, o_sec, o_min, o_hr, o_bcd, o_ovf
  );

  modport slave (
    input  i_en, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    output o_ms_carryup, o_sec_carryup, o_min_carryup, o_hr_carryup,
           o_ms, o_sec, o_min, o_hr, o_bcd, o_ovf
  );
endinterface

// File: rtl/sw_mod_counter.sv
// One stopwatch field: modulo-(MAX+1) up/down counter with synchronous clear
// and a same-cycle carry-up flag.
module sw_mod_counter #(
  parameter int MAX = 99,
  parameter int W   = 7
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic         i_up,
  input  logic         i_down,
  input  logic         i_clr,
  output logic [W-1:0] o_val,
  output logic         o_clr_req,
  output logic         o_carryup
);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] val_q, val_d;
  logic         inc, dec;

  assign inc       = i_en & i_up & ~i_down;
  assign dec       = i_en & i_down & ~i_up;
  assign o_clr_req = i_up & i_down;
  // Clear from any field suppresses every carry so the chain cannot bump a field.
  assign o_carryup = inc & (val_q == MAX_V) & ~i_clr;
  assign o_val     = val_q;

  always_comb begin
    val_d = val_q;
    if (i_clr)    val_d = '0;
    else if (inc) val_d = (val_q >= MAX_V) ? '0 : val_q + 1'b1;
    else if (dec) val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) val_q <= '0;
    else         val_q <= val_d;
  end
endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time register: four chained fields, sticky hours-wrap flag and a
// registered BCD display word {hr,min,sec,ms}.
module stopwatch_time_counter
  import sw_pkg::*;
#(
  parameter int MS_MAX  = MS_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF,
  parameter int HR_MAX  = HR_MAX_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  stopwatch_time_counter_if.slave  bus
);
  localparam int MS_W  = $clog2(MS_MAX + 1);
  localparam int SEC_W = $clog2(SEC_MAX + 1);
  localparam int MIN_W = $clog2(MIN_MAX + 1);
  localparam int HR_W  = $clog2(HR_MAX + 1);
  localparam int FMAX [NUM_FIELDS] = '{MS_MAX, SEC_MAX, MIN_MAX, HR_MAX};

  logic [NUM_FIELDS-1:0]         up, down, clr_req, carry;
  logic [NUM_FIELDS-1:0][FW-1:0] val;
  logic                          clr_any;
  logic                          ovf_q, ovf_d;
  logic [31:0]                   bcd_q, bcd_d;

  assign up      = {bus.i_hr_up,   bus.i_min_up,   bus.i_sec_up,   bus.i_ms_up};
  assign down    = {bus.i_hr_down, bus.i_min_down, bus.i_sec_down, bus.i_ms_down};
  assign clr_any = |clr_req;

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_field
    sw_mod_counter #(.MAX(FMAX[g]), .W(FW)) u_cnt (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_en      (bus.i_en),
      .i_up      (up[g]),
      .i_down    (down[g]),
      .i_clr     (clr_any),
      .o_val     (val[g]),
      .o_clr_req (clr_req[g]),
      .o_carryup (carry[g])
    );
  end

  assign bus.o_ms_carryup  = carry[0];
  assign bus.o_sec_carryup = carry[1];
  assign bus.o_min_carryup = carry[2];
  assign bus.o_hr_carryup  = carry[3];
  assign bus.o_ms          = val[0][MS_W-1:0];
  assign bus.o_sec         = val[1][SEC_W-1:0];
  assign bus.o_min         = val[2][MIN_W-1:0];
  assign bus.o_hr          = val[3][HR_W-1:0];
  assign bus.o_bcd         = bcd_q;
  assign bus.o_ovf         = ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (clr_any)       ovf_d = 1'b0;
    else if (carry[3]) ovf_d = 1'b1;
    bcd_d = '0;
    bcd_d[BCD_HR_LSB  +: 8] = bin2bcd2(val[3]);
    bcd_d[BCD_MIN_LSB +: 8] = bin2bcd2(val[2]);
    bcd_d[BCD_SEC_LSB +: 8] = bin2bcd2(val[1]);
    bcd_d[BCD_MS_LSB  +: 8] = bin2bcd2(val[0]);
  end

  // BCD tracks the field registers, so it lags the binary outputs by one cycle.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ovf_q <= 1'b0;
      bcd_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      bcd_q <= bcd_d;
    end
  end
endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed bench for the stopwatch time register, with an optional model of the
// control's carry chain (sec_up = ms_carry, min_up = sec_carry, hr_up = min_carry).
module tb_stopwatch_time_counter;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       chain = 1'b0;
  logic [3:0] up_r = '0;
  logic [3:0] dn_r = '0;
  int         npass = 0;
  int         ntot = 0;

  always #5 clk = ~clk;

  stopwatch_time_counter_if bus ();

  assign bus.i_en       = en;
  assign bus.i_ms_up    = up_r[0];
  assign bus.i_sec_up   = up_r[1] | (chain & bus.o_ms_carryup);
  assign bus.i_min_up   = up_r[2] | (chain & bus.o_sec_carryup);
  assign bus.i_hr_up    = up_r[3] | (chain & bus.o_min_carryup);
  assign bus.i_ms_down  = dn_r[0];
  assign bus.i_sec_down = dn_r[1];
  assign bus.i_min_down = dn_r[2];
  assign bus.i_hr_down  = dn_r[3];

  stopwatch_time_counter dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hms();
    return {8'(bus.o_hr), 8'(bus.o_min), 8'(bus.o_sec), 8'(bus.o_ms)};
  endfunction

  function automatic logic [3:0] carries();
    return {bus.o_hr_carryup, bus.o_min_carryup, bus.o_sec_carryup, bus.o_ms_carryup};
  endfunction

  initial begin
    repeat (2) step();
    chk("reset_fields", hms(), 32'h0);
    chk("reset_bcd", bus.o_bcd, 32'h0);
    chk("reset_ovf", 32'(bus.o_ovf), 32'h0);
    chk("reset_carry", 32'(carries()), 32'h0);
    rstn = 1'b1;
    step();

    // ms counts 0..99 then wraps; carry only while ms == 99
    en = 1'b1;
    up_r = 4'b0001;
    #1;
    for (int i = 0; i < 100; i++) begin
      chk("t1_ms", 32'(bus.o_ms), 32'(i));
      chk("t1_carry", 32'(bus.o_ms_carryup), (i == 99) ? 32'h1 : 32'h0);
      step();
    end
    chk("t1_wrap", hms(), 32'h0);
    up_r = '0;

    // preload 00:59:59.00 with down strobes, then 100 chained ticks -> 01:00:00.00
    dn_r = 4'b0110;
    #1;
    chk("t4_down_carry", 32'(carries()), 32'h0);
    step();
    dn_r = '0;
    chk("t4_preload", hms(), {8'd0, 8'd59, 8'd59, 8'd0});
    chain = 1'b1;
    up_r = 4'b0001;
    repeat (100) step();
    up_r = '0;
    chain = 1'b0;
    chk("t2_hour", hms(), {8'd1, 8'd0, 8'd0, 8'd0});
    step();
    chk("t2_bcd", bus.o_bcd, 32'h01000000);

    // hr chord clears everything even with an ms up strobe present
    up_r = 4'b1001;
    dn_r = 4'b1000;
    #1;
    chk("clr_hr_carry", 32'(carries()), 32'h0);
    step();
    up_r = '0;
    dn_r = '0;
    chk("clr_hr_fields", hms(), 32'h0);

    // all fields 0 -> down -> MAX, no carries
    dn_r = 4'b1111;
    #1;
    chk("t4_all_down_carry", 32'(carries()), 32'h0);
    step();
    dn_r = '0;
    chk("t4_all_max", hms(), {8'd23, 8'd59, 8'd59, 8'd99});
    step();
    chk("t3_bcd_pre", bus.o_bcd, 32'h23595999);
    chk("t3_ovf_pre", 32'(bus.o_ovf), 32'h0);

    // one chained tick from 23:59:59.99
    chain = 1'b1;
    up_r = 4'b0001;
    #1;
    chk("t3_carries", 32'(carries()), 32'hF);
    step();
    up_r = '0;
    chk("t3_wrap", hms(), 32'h0);
    chk("t3_ovf", 32'(bus.o_ovf), 32'h1);
    chk("t3_hr_carry_off", 32'(bus.o_hr_carryup), 32'h0);
    step();
    chain = 1'b0;
    chk("t3_ovf_sticky", 32'(bus.o_ovf), 32'h1);
    chk("t3_bcd", bus.o_bcd, 32'h0);

    // build 01:02:03.04 with single up strobes
    up_r = 4'b1111; step();
    up_r = 4'b0111; step();
    up_r = 4'b0011; step();
    up_r = 4'b0001; step();
    up_r = '0;
    chk("t5_load", hms(), {8'd1, 8'd2, 8'd3, 8'd4});
    step();
    chk("t5_bcd", bus.o_bcd, 32'h01020304);
    chk("t5_ovf_pre", 32'(bus.o_ovf), 32'h1);

    // ms chord with en low still clears fields and ovf
    en = 1'b0;
    up_r = 4'b0001;
    dn_r = 4'b0001;
    #1;
    chk("t5_clr_carry", 32'(carries()), 32'h0);
    step();
    up_r = '0;
    dn_r = '0;
    chk("t5_clr_fields", hms(), 32'h0);
    chk("t5_clr_ovf", 32'(bus.o_ovf), 32'h0);

    // async reset between edges
    en = 1'b1;
    up_r = 4'b0001;
    repeat (5) step();
    chk("t6_pre", 32'(bus.o_ms), 32'd5);
    step();
    chk("t6_bcd_pre", bus.o_bcd, 32'h00000005);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_rst_ms", 32'(bus.o_ms), 32'h0);
    chk("t6_rst_bcd", bus.o_bcd, 32'h0);
    #1;
    rstn = 1'b1;
    repeat (3) step();
    chk("t6_resume", 32'(bus.o_ms), 32'd3);
    up_r = '0;
    en = 1'b0;
    step();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
